fault_alarm: RTL and testbench
==============================

FAULT_ALARM -- requirements
Module: fault_alarm

Interface
REQ-001 SHALL have parameter PERSIST, default 4, range 1..7: consecutive qualifying samples needed to raise a channel alarm.
REQ-002 SHALL have parameter SEV_MIN, default 1, range 1..4: minimum severity code that counts as a qualifying sample.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sev  input  3  severity code from the fault processor (0 none, 1..4 increasing; 5..7 treated as 4).
REQ-006 SHALL have port chan  input  2  channel index associated with sev.
REQ-007 SHALL have port ack  input  1  operator acknowledge strobe.
REQ-008 SHALL have port ack_chan  input  2  channel being acknowledged.
REQ-009 SHALL have port alarm  output  1  OR of all channel alarm states.
REQ-010 SHALL have port ch_status  output  12  latched severity per channel; bits [3k+2:3k] belong to channel k, 0 when not in ALARM.
REQ-011 SHALL have port evt_valid  output  1  event FIFO non-empty.
REQ-012 SHALL have port evt_ready  input  1  consumer accepts the head event when high together with evt_valid.
REQ-013 SHALL have port evt_chan  output  2  channel of the head event.
REQ-014 SHALL have port evt_sev  output  3  severity of the head event.
REQ-015 SHALL have port overflow  output  1  sticky flag: an event was dropped.

Function
REQ-016 SHALL sample sev/chan every cycle; a sample is qualifying when the clamped sev >= SEV_MIN.
REQ-017 SHALL keep per channel a 3-bit persistence counter cnt[k] and a 2-state FSM {IDLE, ALARM}.
REQ-018 In IDLE: qualifying sample on chan==k -> cnt[k]+1, saturating at PERSIST; non-qualifying sample on chan==k -> cnt[k]=0; chan!=k -> cnt[k] unchanged.
REQ-019 In IDLE: a sample bringing cnt[k] to PERSIST SHALL move channel k to ALARM on that edge, latching pk[k] = max clamped sev seen during the current run.
REQ-020 In ALARM: qualifying sample on chan==k with sev > pk[k] SHALL update pk[k] (escalation); lower or non-qualifying samples SHALL NOT change pk[k] or leave ALARM.
REQ-021 ALARM -> IDLE only on ack with ack_chan==k; cnt[k] and pk[k] cleared on that edge.
REQ-022 If ack targets channel k on the same edge as a qualifying sample for k, ack SHALL win and the sample SHALL count as cnt[k]=1 in IDLE (PERSIST=1: re-enter ALARM immediately).
REQ-023 ack to a channel in IDLE SHALL clear cnt[k] only and generate no event.
REQ-024 alarm and ch_status SHALL reflect the FSM state registered on the same edge (latency 1 cycle from the deciding sample).
REQ-025 SHALL push one event {chan, sev} to a 4-entry FIFO on each IDLE->ALARM entry and on each escalation; at most one push per cycle, since one sample is processed per cycle.
REQ-026 Pop SHALL occur when evt_valid && evt_ready; evt_chan/evt_sev SHALL present the head entry combinationally from registers and hold stable while evt_valid && !evt_ready.
REQ-027 Push when full without simultaneous pop SHALL drop the new event and set overflow; push and pop on the same edge when full SHALL succeed.
REQ-028 Push and pop on the same edge when empty SHALL NOT bypass: the event appears on evt_valid the next cycle.
REQ-029 FIFO read/write pointers SHALL wrap modulo 4; occupancy SHALL be tracked with a 3-bit count (0..4).

Reset
REQ-030 On reset high at a clock edge: all FSMs IDLE, cnt=0, pk=0, FIFO empty, alarm=0, ch_status=0, evt_valid=0, evt_chan=0, evt_sev=0, overflow=0.
REQ-031 Reset SHALL override all inputs in the same cycle, including mid-run persistence and pending FIFO events, which are discarded.
REQ-032 overflow SHALL clear only on reset.

Verification
REQ-033 PERSIST=4: chan=2, sev=3 for 4 cycles -> alarm=1 and ch_status[8:6]=3 after the 4th edge; one event {2,3} is readable.
REQ-034 chan=1 sev=2 for 3 cycles, sev=0 once, then sev=2 for 3 cycles -> no alarm; cnt[1]=3.
REQ-035 Channel 0 in ALARM pk=1; sev=4 sample on chan 0 -> ch_status[2:0]=4 and a second event {0,4} is queued; sev=2 -> no change.
REQ-036 evt_ready=0, five distinct alarm/escalation events -> 4 held in order, overflow=1; drain -> four events in push order, then evt_valid=0.
REQ-037 Channel 3 in ALARM; ack with ack_chan=3 on the same edge as a sev=4 chan=3 sample -> ch_status[11:9]=0, cnt[3]=1, alarm=0 (unless another channel is in ALARM).
REQ-038 Reset asserted while 2 events are queued and channel 1 is in ALARM -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/fault_alarm.sv
// rtl/fault_alarm.sv - per-channel fault persistence alarm with event FIFO
module fault_alarm #(
    parameter int PERSIST = 4,
    parameter int SEV_MIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  sev,
    input  logic [1:0]  chan,
    input  logic        ack,
    input  logic [1:0]  ack_chan,
    output logic        alarm,
    output logic [11:0] ch_status,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [1:0]  evt_chan,
    output logic [2:0]  evt_sev,
    output logic        overflow
);
    typedef enum logic {IDLE, ALARM} state_t;

    localparam logic [2:0] PERSIST_L = 3'(PERSIST);
    localparam logic [2:0] SEV_MIN_L = 3'(SEV_MIN);

    state_t     state      [4];
    logic [2:0] cnt        [4];
    logic [2:0] pk         [4];
    logic [2:0] run_max    [4];
    state_t     nxt_state  [4];
    logic [2:0] nxt_cnt    [4];
    logic [2:0] nxt_pk     [4];
    logic [2:0] nxt_max    [4];
    logic       nxt_alarm;
    logic [11:0] nxt_status;

    logic [2:0] sev_c;
    logic       qual;
    logic       push;
    logic [2:0] push_sev;

    logic [1:0] mem_chan [4];
    logic [2:0] mem_sev  [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       pop;
    logic       do_push;

    assign sev_c = (sev > 3'd4) ? 3'd4 : sev;
    assign qual  = (sev_c >= SEV_MIN_L);

    // An ack is applied first, so a coincident sample starts a fresh run from IDLE.
    always_comb begin
        push       = 1'b0;
        push_sev   = 3'd0;
        nxt_alarm  = 1'b0;
        nxt_status = 12'd0;
        for (int k = 0; k < 4; k++) begin
            logic acked;
            acked        = ack && (ack_chan == 2'(k));
            nxt_state[k] = acked ? IDLE : state[k];
            nxt_cnt[k]   = acked ? 3'd0 : cnt[k];
            nxt_max[k]   = acked ? 3'd0 : run_max[k];
            nxt_pk[k]    = acked ? 3'd0 : pk[k];
            if (chan == 2'(k)) begin
                if (nxt_state[k] == IDLE) begin
                    if (qual) begin
                        nxt_cnt[k] = (nxt_cnt[k] >= PERSIST_L) ? PERSIST_L : nxt_cnt[k] + 3'd1;
                        nxt_max[k] = (sev_c > nxt_max[k]) ? sev_c : nxt_max[k];
                        if (nxt_cnt[k] == PERSIST_L) begin
                            nxt_state[k] = ALARM;
                            nxt_pk[k]    = nxt_max[k];
                            push         = 1'b1;
                            push_sev     = nxt_max[k];
                        end
                    end else begin
                        nxt_cnt[k] = 3'd0;
                        nxt_max[k] = 3'd0;
                    end
                end else if (qual && (sev_c > nxt_pk[k])) begin
                    nxt_pk[k] = sev_c;
                    push      = 1'b1;
                    push_sev  = sev_c;
                end
            end
            if (nxt_state[k] == ALARM) begin
                nxt_alarm          = 1'b1;
                nxt_status[3*k +: 3] = nxt_pk[k];
            end
        end
    end

    assign evt_valid = (count != 3'd0);
    assign pop       = evt_valid && evt_ready;
    assign do_push   = push && ((count != 3'd4) || pop);
    assign evt_chan  = evt_valid ? mem_chan[rd_ptr] : 2'd0;
    assign evt_sev   = evt_valid ? mem_sev[rd_ptr]  : 3'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                state[k]    <= IDLE;
                cnt[k]      <= 3'd0;
                pk[k]       <= 3'd0;
                run_max[k]  <= 3'd0;
                mem_chan[k] <= 2'd0;
                mem_sev[k]  <= 3'd0;
            end
            alarm     <= 1'b0;
            ch_status <= 12'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            overflow  <= 1'b0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                state[k]   <= nxt_state[k];
                cnt[k]     <= nxt_cnt[k];
                pk[k]      <= nxt_pk[k];
                run_max[k] <= nxt_max[k];
            end
            alarm     <= nxt_alarm;
            ch_status <= nxt_status;
            if (do_push) begin
                mem_chan[wr_ptr] <= chan;
                mem_sev[wr_ptr]  <= push_sev;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fault_alarm.sv
// tb/tb_fault_alarm.sv - directed self-checking bench for fault_alarm
module tb_fault_alarm;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  sev = 3'd0;
    logic [1:0]  chan = 2'd0;
    logic        ack = 1'b0;
    logic [1:0]  ack_chan = 2'd0;
    logic        alarm;
    logic [11:0] ch_status;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [1:0]  evt_chan;
    logic [2:0]  evt_sev;
    logic        overflow;

    int total = 0;
    int bad = 0;

    fault_alarm #(.PERSIST(4), .SEV_MIN(1)) dut (
        .clk(clk), .reset(reset), .sev(sev), .chan(chan), .ack(ack), .ack_chan(ack_chan),
        .alarm(alarm), .ch_status(ch_status), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_chan(evt_chan), .evt_sev(evt_sev), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [1:0] c, input logic [2:0] s, input int n);
        chan = c;
        sev  = s;
        for (int i = 0; i < n; i++) tick();
        sev = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm: got %0b want 0", alarm); end
        total++; if (ch_status !== 12'h000) begin bad++; $display("FAIL reset_status: got %h want 000", ch_status); end
        total++; if ({evt_valid, evt_chan, evt_sev, overflow} !== 7'd0) begin bad++; $display("FAIL reset_fifo: got %b want 0000000", {evt_valid, evt_chan, evt_sev, overflow}); end
    endtask

    task automatic test_persist();
        sample(2'd2, 3'd3, 3);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL persist_early: got %0b want 0", alarm); end
        sample(2'd2, 3'd3, 1);
        total++; if (alarm !== 1'b1) begin bad++; $display("FAIL persist_alarm: got %0b want 1", alarm); end
        total++; if (ch_status !== 12'h0C0) begin bad++; $display("FAIL persist_status: got %h want 0c0", ch_status); end
        total++; if ({evt_valid, evt_chan, evt_sev} !== {1'b1, 2'd2, 3'd3}) begin bad++; $display("FAIL persist_event: got v=%0b c=%0d s=%0d want v=1 c=2 s=3", evt_valid, evt_chan, evt_sev); end
        chan = 2'd0; evt_ready = 1'b1; ack = 1'b1; ack_chan = 2'd2;
        tick();
        evt_ready = 1'b0; ack = 1'b0;
        total++; if ({alarm, evt_valid} !== 2'b00) begin bad++; $display("FAIL persist_clear: got alarm=%0b valid=%0b want 0 0", alarm, evt_valid); end
    endtask

    task automatic test_run_reset();
        sample(2'd1, 3'd2, 3);
        sample(2'd1, 3'd0, 1);
        sample(2'd1, 3'd2, 3);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL run_noalarm: got %0b want 0", alarm); end
        sample(2'd1, 3'd2, 1);
        total++; if ({alarm, ch_status} !== {1'b1, 12'h010}) begin bad++; $display("FAIL run_fourth: got alarm=%0b status=%h want 1 010", alarm, ch_status); end
        chan = 2'd0; evt_ready = 1'b1; ack = 1'b1; ack_chan = 2'd1;
        tick();
        evt_ready = 1'b0; ack = 1'b0;
    endtask

    task automatic test_escalation();
        sample(2'd0, 3'd1, 4);
        total++; if (ch_status !== 12'h001) begin bad++; $display("FAIL esc_entry: got %h want 001", ch_status); end
        sample(2'd0, 3'd4, 1);
        total++; if (ch_status !== 12'h004) begin bad++; $display("FAIL esc_raise: got %h want 004", ch_status); end
        sample(2'd0, 3'd2, 1);
        total++; if (ch_status !== 12'h004) begin bad++; $display("FAIL esc_lower: got %h want 004", ch_status); end
        total++; if ({evt_chan, evt_sev} !== {2'd0, 3'd1}) begin bad++; $display("FAIL esc_head1: got c=%0d s=%0d want c=0 s=1", evt_chan, evt_sev); end
        evt_ready = 1'b1;
        tick();
        total++; if ({evt_valid, evt_chan, evt_sev} !== {1'b1, 2'd0, 3'd4}) begin bad++; $display("FAIL esc_head2: got v=%0b c=%0d s=%0d want v=1 c=0 s=4", evt_valid, evt_chan, evt_sev); end
        tick();
        evt_ready = 1'b0;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL esc_drained: got %0b want 0", evt_valid); end
        sample(2'd0, 3'd7, 1);
        total++; if ({evt_valid, ch_status} !== {1'b0, 12'h004}) begin bad++; $display("FAIL esc_clamp: got valid=%0b status=%h want 0 004", evt_valid, ch_status); end
        ack = 1'b1; ack_chan = 2'd0; chan = 2'd1;
        tick();
        ack = 1'b0;
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL esc_ack: got %0b want 0", alarm); end
    endtask

    task automatic test_overflow();
        logic [1:0] exp_c [4];
        logic [2:0] exp_s [4];
        exp_c[0] = 2'd1; exp_s[0] = 3'd2;
        exp_c[1] = 2'd2; exp_s[1] = 3'd3;
        exp_c[2] = 2'd3; exp_s[2] = 3'd1;
        exp_c[3] = 2'd1; exp_s[3] = 3'd4;
        sample(2'd0, 3'd1, 4);
        sample(2'd1, 3'd2, 4);
        sample(2'd2, 3'd3, 4);
        sample(2'd3, 3'd1, 4);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_full_only: got %0b want 0", overflow); end
        sample(2'd0, 3'd3, 1);
        total++; if ({overflow, ch_status[2:0]} !== {1'b1, 3'd3}) begin bad++; $display("FAIL ovf_drop: got ovf=%0b st0=%0d want 1 3", overflow, ch_status[2:0]); end
        evt_ready = 1'b1;
        sample(2'd1, 3'd4, 1);
        for (int i = 0; i < 4; i++) begin
            total++; if ({evt_valid, evt_chan, evt_sev} !== {1'b1, exp_c[i], exp_s[i]}) begin bad++; $display("FAIL ovf_drain%0d: got v=%0b c=%0d s=%0d want v=1 c=%0d s=%0d", i, evt_valid, evt_chan, evt_sev, exp_c[i], exp_s[i]); end
            tick();
        end
        evt_ready = 1'b0;
        total++; if ({evt_valid, overflow} !== 2'b01) begin bad++; $display("FAIL ovf_empty: got valid=%0b ovf=%0b want 0 1", evt_valid, overflow); end
        ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ack_chan = 2'(k);
            tick();
        end
        ack = 1'b0;
        total++; if ({alarm, ch_status} !== 13'd0) begin bad++; $display("FAIL ovf_acked: got alarm=%0b status=%h want 0 000", alarm, ch_status); end
    endtask

    task automatic test_ack_collision();
        sample(2'd3, 3'd2, 4);
        total++; if (ch_status !== 12'h400) begin bad++; $display("FAIL col_entry: got %h want 400", ch_status); end
        chan = 2'd0; evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        ack = 1'b1; ack_chan = 2'd3;
        sample(2'd3, 3'd4, 1);
        ack = 1'b0;
        total++; if ({alarm, ch_status, evt_valid} !== 14'd0) begin bad++; $display("FAIL col_ackwins: got alarm=%0b status=%h valid=%0b want 0 000 0", alarm, ch_status, evt_valid); end
        sample(2'd3, 3'd4, 2);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL col_cnt_early: got %0b want 0", alarm); end
        sample(2'd3, 3'd4, 1);
        total++; if ({alarm, ch_status} !== {1'b1, 12'h800}) begin bad++; $display("FAIL col_cnt_one: got alarm=%0b status=%h want 1 800", alarm, ch_status); end
        chan = 2'd0; evt_ready = 1'b1; ack = 1'b1; ack_chan = 2'd3;
        tick();
        evt_ready = 1'b0; ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        sample(2'd1, 3'd2, 4);
        sample(2'd1, 3'd3, 1);
        sample(2'd2, 3'd1, 2);
        total++; if ({alarm, evt_valid, evt_chan, evt_sev} !== {1'b1, 1'b1, 2'd1, 3'd2}) begin bad++; $display("FAIL mid_setup: got alarm=%0b v=%0b c=%0d s=%0d want 1 1 1 2", alarm, evt_valid, evt_chan, evt_sev); end
        reset = 1'b1; chan = 2'd2; sev = 3'd1;
        tick();
        reset = 1'b0; sev = 3'd0;
        total++; if ({alarm, ch_status, evt_valid, evt_chan, evt_sev, overflow} !== 20'd0) begin bad++; $display("FAIL mid_reset: got %h want 00000", {alarm, ch_status, evt_valid, evt_chan, evt_sev, overflow}); end
        sample(2'd2, 3'd1, 3);
        total++; if (alarm !== 1'b0) begin bad++; $display("FAIL mid_run_discard: got %0b want 0", alarm); end
        sample(2'd2, 3'd1, 1);
        total++; if ({alarm, evt_valid, evt_chan, evt_sev} !== {1'b1, 1'b1, 2'd2, 3'd1}) begin bad++; $display("FAIL mid_after: got alarm=%0b v=%0b c=%0d s=%0d want 1 1 2 1", alarm, evt_valid, evt_chan, evt_sev); end
    endtask

    initial begin
        test_reset();
        test_persist();
        test_run_reset();
        test_escalation();
        test_overflow();
        test_ack_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
